// File: rtl/regfile32_pkg.sv
// Shared sizing constants for the 32-entry register file.
// Module parameters default to these values so every file agrees on geometry.
package regfile32_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
endpackage

// File: rtl/regfile32_entry.sv
// One register-file word: synchronous active-high clear, load enable.
// Latency: loaded value visible one cycle after the load edge.
module regfile_entry #(
    parameter int W = regfile32_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/regfile32.sv
// Two-read, one-write register file; register 0 hardwired to zero.
// Reads are combinational with optional write-first forwarding; writes land on the next edge.
module regfile32 #(
    parameter int DATA_W = regfile32_pkg::DATA_W,
    parameter int ADDR_W = regfile32_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0]             load_en;
    logic [NUM_REGS-1:0][DATA_W-1:0] reg_val;
    logic                            wr_live;
    logic [DATA_W-1:0]               mux1;
    logic [DATA_W-1:0]               mux2;

    // A write is only live when it can actually land: reset and r0 both kill it.
    assign wr_live = we && !rst && (wr_addr != '0);

    always_comb begin
        load_en = '0;
        if (wr_live) begin
            load_en[wr_addr] = 1'b1;
        end
    end

    assign reg_val[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        regfile_entry #(.W(DATA_W)) u_entry (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_en[i]),
            .d_i    (wr_data),
            .q_o    (reg_val[i])
        );
    end

    assign mux1 = reg_val[rd_addr1];
    assign mux2 = reg_val[rd_addr2];

    always_comb begin
        rd_data1 = mux1;
        rd_data2 = mux2;
        if ((BYPASS != 0) && wr_live) begin
            if (rd_addr1 == wr_addr) rd_data1 = wr_data;
            if (rd_addr2 == wr_addr) rd_data2 = wr_data;
        end
    end
endmodule
